// File: rtl/data_mem_responder.sv
// Data memory responder for the MEM stage: serializes one load or store at a
// time through a word-addressed RAM with a fixed multi-cycle latency.
module data_mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] write_data,
  output logic [WORD_SIZE-1:0] read_data,
  output logic                 mem_stall,
  output logic                 done,
  output logic                 req_conflict
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   data_q;
  logic                   is_store_q;
  logic                   req, accept, commit;

  logic [WORD_SIZE-1:0]   ram [2**ADDR_BITS];

  generate
    if (WORD_SIZE > ADDR_BITS) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];
    end
  endgenerate

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    req       = mem_read | mem_write;
    state_d   = state_q;
    mem_stall = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall is combinational on the request but must stay low in reset.
        mem_stall = req & reset_n;
        if (req) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      data_q       <= '0;
      is_store_q   <= 1'b0;
      read_data    <= '0;
      req_conflict <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= address[ADDR_BITS-1:0];
        data_q     <= write_data;
        is_store_q <= mem_write;
        cnt_q      <= CNT_INIT;
        if (mem_read && mem_write) req_conflict <= 1'b1;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit && !is_store_q) read_data <= ram[addr_q];
    end
  end

  // NOTE: the RAM array has no reset; its contents must survive reset_n.
  always_ff @(posedge clk) begin
    if (commit && is_store_q) ram[addr_q] <= data_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a
// transaction-level model of the RAM, read result and conflict flag.
module tb_data_mem_responder;

  localparam int WS  = 16;
  localparam int AB  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [WS-1:0] address = '0;
  logic [WS-1:0] write_data = '0;
  logic [WS-1:0] read_data;
  logic          mem_stall;
  logic          done;
  logic          req_conflict;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WS-1:0] mem_model [2**AB];
  logic [WS-1:0] rd_model;
  bit            conflict_model;

  data_mem_responder #(.WORD_SIZE(WS), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .mem_stall(mem_stall), .done(done), .req_conflict(req_conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // mode 0: drop request, 1: random junk, 2: switch to store of 0xFFFF at 0x0002
  task automatic drive_junk(input int mode);
    case (mode)
      1: begin
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        address    = WS'($urandom);
        write_data = WS'($urandom);
      end
      2: begin
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        address    = 16'h0002;
        write_data = 16'hFFFF;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  endtask

  // Called just after a rising edge with the DUT idle; returns just after an edge.
  task automatic do_access(input bit rd, input bit wr, input logic [WS-1:0] a,
                           input logic [WS-1:0] d, input int mode, input bit gap,
                           input string tag);
    logic [WS-1:0] rd_exp;
    rd_exp = wr ? rd_model : mem_model[a[AB-1:0]];
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: stall=%b done=%b, want stall=1 done=0", tag, mem_stall, done);
    end
    @(posedge clk); #1;
    if (wr) mem_model[a[AB-1:0]] = d;
    if (rd && wr) conflict_model = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      drive_junk(mode);
      @(negedge clk);
      n_tests++;
      if (mem_stall !== 1'b1 || done !== 1'b0 || read_data !== rd_model) begin
        n_fail++;
        $display("FAIL %s busy%0d: stall=%b done=%b rdata=%h, want 1 0 %h",
                 tag, i, mem_stall, done, read_data, rd_model);
      end
      @(posedge clk); #1;
    end
    drive_junk(mode);
    @(negedge clk);
    n_tests++;
    if (mem_stall !== 1'b0 || done !== 1'b1 || read_data !== rd_exp
        || req_conflict !== conflict_model) begin
      n_fail++;
      $display("FAIL %s done: stall=%b done=%b rdata=%h conflict=%b, want 0 1 %h %b",
               tag, mem_stall, done, read_data, req_conflict, rd_exp, conflict_model);
    end
    @(posedge clk); #1;
    rd_model = rd_exp;
    drive_junk(0);
    if (gap) begin
      @(negedge clk);
      n_tests++;
      if (mem_stall !== 1'b0 || done !== 1'b0 || read_data !== rd_model) begin
        n_fail++;
        $display("FAIL %s idle: stall=%b done=%b rdata=%h, want 0 0 %h",
                 tag, mem_stall, done, read_data, rd_model);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_read = 1'b1; address = 16'h0005;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (mem_stall !== 1'b0 || done !== 1'b0 || read_data !== '0 || req_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: stall=%b done=%b rdata=%h conflict=%b, want 0 0 0000 0",
               mem_stall, done, read_data, req_conflict);
    end
    mem_read = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    do_access(1'b0, 1'b1, 16'h0005, 16'h1234, 0, 1'b1, "store5");
    n_tests++;
    if (read_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL store_keeps_rdata: rdata=%h want 0000", read_data);
    end
    do_access(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 1'b1, "load5");
    n_tests++;
    if (read_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL load5_value: rdata=%h want 1234", read_data);
    end
  endtask

  task automatic test_wrap();
    do_access(1'b0, 1'b1, 16'h0107, 16'hBEEF, 0, 1'b1, "wrap_store");
    do_access(1'b1, 1'b0, 16'h0007, 16'h0000, 0, 1'b1, "wrap_load");
    n_tests++;
    if (read_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wrap_value: rdata=%h want beef", read_data);
    end
  endtask

  task automatic test_conflict();
    do_access(1'b1, 1'b1, 16'h0003, 16'h00AA, 0, 1'b1, "conflict");
    do_access(1'b1, 1'b0, 16'h0003, 16'h0000, 0, 1'b1, "conflict_load");
    n_tests++;
    if (read_data !== 16'h00AA || req_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_sticky: rdata=%h conflict=%b want 00aa 1", read_data, req_conflict);
    end
  endtask

  task automatic test_reset_mid_busy();
    mem_write = 1'b1; address = 16'h0009; write_data = 16'h5555;
    @(posedge clk); #1;
    mem_write = 1'b0;
    n_tests++;
    if (mem_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy: stall=%b want 1", mem_stall);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (mem_stall !== 1'b0 || done !== 1'b0 || read_data !== '0 || req_conflict !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: stall=%b done=%b rdata=%h conflict=%b want 0 0 0000 0",
               mem_stall, done, read_data, req_conflict);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    rd_model = '0;
    conflict_model = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (mem_stall !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_quiet%0d: stall=%b done=%b want 0 0", i, mem_stall, done);
      end
      @(posedge clk); #1;
    end
    do_access(1'b1, 1'b0, 16'h0009, 16'h0000, 0, 1'b1, "midreset_load");
    n_tests++;
    if (read_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_ram: rdata=%h want 0000", read_data);
    end
  endtask

  task automatic test_latched();
    do_access(1'b0, 1'b1, 16'h0011, 16'h4321, 2, 1'b1, "latched_store");
    do_access(1'b1, 1'b0, 16'h0011, 16'h0000, 0, 1'b1, "latched_load");
    n_tests++;
    if (read_data !== 16'h4321) begin
      n_fail++;
      $display("FAIL latched_value: rdata=%h want 4321", read_data);
    end
    do_access(1'b1, 1'b0, 16'h0002, 16'h0000, 0, 1'b1, "latched_ignored");
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b1, 16'h0020, 16'hA5A5, 1, 1'b0, "b2b_store");
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 1, 1'b0, "b2b_load");
    do_access(1'b0, 1'b1, 16'h0020, 16'h0F0F, 1, 1'b0, "b2b_store2");
    do_access(1'b1, 1'b0, 16'h0120, 16'h0000, 0, 1'b1, "b2b_load2");
    n_tests++;
    if (read_data !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL b2b_value: rdata=%h want 0f0f", read_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int op;
      logic [WS-1:0] a;
      op = int'($urandom_range(0, 4));
      a = WS'($urandom);
      a[AB-1:0] = AB'($urandom_range(0, 15));
      do_access(op <= 1 || op == 4, op >= 2, a, WS'($urandom), int'($urandom_range(0, 1)),
                1'($urandom), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AB; i++) mem_model[i] = '0;
    rd_model = '0;
    conflict_model = 1'b0;
    test_reset();
    test_store_load();
    test_wrap();
    test_conflict();
    test_reset_mid_busy();
    test_latched();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
